// File: rtl/stripes_slice_sequencer.sv
// Bit-serial step sequencer for one Stripes SIP slice (Tn=1, Tw windows).
// Define STRIPES_SEQ_PERF_CNT_EN to add saturating busy/stall/backpressure counters.
module stripes_slice_sequencer #(
    parameter int TW       = 16,
    parameter int PIPE_LAT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [4:0]       i_precision,
    input  logic [CNT_W-1:0] i_num_bricks,
    input  logic [CNT_W-1:0] i_num_outputs,
    input  logic             i_maxpool,
    input  logic [TW-1:0]    i_window_mask,
    input  logic             i_in_valid,
    input  logic             i_out_ready,
    output logic             o_in_rd_en,
    output logic             o_first_cycle,
    output logic [4:0]       o_precision,
    output logic             o_maxpool,
    output logic [TW-1:0]    o_load,
    output logic             o_out_valid,
    output logic             o_busy,
`ifdef STRIPES_SEQ_PERF_CNT_EN
    output logic [31:0]      o_cyc_cnt,
    output logic [31:0]      o_stall_cnt,
    output logic [31:0]      o_bp_cnt,
`endif
    output logic             o_done
);

    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [4:0]       prec_q;
    logic [CNT_W-1:0] nb_q;
    logic [CNT_W-1:0] nout_q;
    logic             mp_q;
    logic [TW-1:0]    mask_q;

    logic [4:0]       bit_q;
    logic [CNT_W-1:0] brick_q;
    logic [CNT_W-1:0] grp_q;
    logic [DW-1:0]    drain_q;

    logic [4:0]       prec_clamp;
    logic [CNT_W-1:0] nb_clamp;
    logic             accept;
    logic             step;
    logic             last_bit;
    logic             last_brick;
    logic             last_grp;
    logic             drain_last;
    logic             handshake;

    always_comb begin
        prec_clamp = i_precision;
        if (i_precision == 5'd0)
            prec_clamp = 5'd1;
        else if (i_precision > 5'd16)
            prec_clamp = 5'd16;
    end

    assign nb_clamp   = (i_num_bricks == '0) ? CNT_W'(1) : i_num_bricks;
    assign accept     = (state_q == S_IDLE) && i_start;
    assign step       = (state_q == S_RUN) && i_in_valid;
    assign last_bit   = (bit_q == prec_q - 5'd1);
    assign last_brick = (brick_q == nb_q - CNT_W'(1));
    assign last_grp   = (grp_q == nout_q - CNT_W'(1));
    assign drain_last = (drain_q == DRAIN_LAST);
    assign handshake  = (state_q == S_OUT) && i_out_ready;

    always_comb begin
        state_d       = state_q;
        o_in_rd_en    = 1'b0;
        o_first_cycle = 1'b0;
        o_load        = '0;
        o_out_valid   = 1'b0;
        o_done        = 1'b0;
        o_busy        = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (i_start)
                    state_d = (i_num_outputs == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                o_in_rd_en    = i_in_valid;
                o_first_cycle = i_in_valid && (bit_q == 5'd0)
                                && (brick_q == '0);
                if (step && last_bit && last_brick)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_last) begin
                    o_load  = mask_q;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                o_out_valid = 1'b1;
                if (i_out_ready)
                    state_d = last_grp ? S_DONE : S_RUN;
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            prec_q  <= '0;
            nb_q    <= '0;
            nout_q  <= '0;
            mp_q    <= 1'b0;
            mask_q  <= '0;
            bit_q   <= '0;
            brick_q <= '0;
            grp_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                prec_q  <= prec_clamp;
                nb_q    <= nb_clamp;
                nout_q  <= i_num_outputs;
                mp_q    <= i_maxpool;
                mask_q  <= i_window_mask;
                bit_q   <= '0;
                brick_q <= '0;
                grp_q   <= '0;
                drain_q <= '0;
            end
            // Bit counter is innermost; brick advances on each bit wrap.
            if (step) begin
                if (last_bit) begin
                    bit_q   <= '0;
                    brick_q <= last_brick ? '0 : brick_q + CNT_W'(1);
                end else begin
                    bit_q <= bit_q + 5'd1;
                end
            end
            if (state_q == S_DRAIN)
                drain_q <= drain_last ? '0 : drain_q + DW'(1);
            if (handshake && !last_grp)
                grp_q <= grp_q + CNT_W'(1);
        end
    end

    assign o_precision = prec_q;
    assign o_maxpool   = mp_q;

`ifdef STRIPES_SEQ_PERF_CNT_EN
    logic [31:0] cyc_q, stall_q, bp_q;

    always_ff @(posedge clk) begin
        if (reset || accept) begin
            cyc_q   <= '0;
            stall_q <= '0;
            bp_q    <= '0;
        end else begin
            if (state_q != S_IDLE && cyc_q != '1)
                cyc_q <= cyc_q + 32'd1;
            if (state_q == S_RUN && !i_in_valid && stall_q != '1)
                stall_q <= stall_q + 32'd1;
            if (state_q == S_OUT && !i_out_ready && bp_q != '1)
                bp_q <= bp_q + 32'd1;
        end
    end

    assign o_cyc_cnt   = cyc_q;
    assign o_stall_cnt = stall_q;
    assign o_bp_cnt    = bp_q;
`endif

endmodule

// File: tb/tb_stripes_slice_sequencer.sv
// Self-checking bench for stripes_slice_sequencer: table of layer configs
// with a scoreboard of expected per-layer results, plus reset/abort sequences.
module tb_stripes_slice_sequencer;

    localparam int TW = 16;
    localparam int PL = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_start;
    logic [4:0]    i_precision;
    logic [CW-1:0] i_num_bricks;
    logic [CW-1:0] i_num_outputs;
    logic          i_maxpool;
    logic [TW-1:0] i_window_mask;
    logic          i_in_valid;
    logic          i_out_ready;
    logic          o_in_rd_en;
    logic          o_first_cycle;
    logic [4:0]    o_precision;
    logic          o_maxpool;
    logic [TW-1:0] o_load;
    logic          o_out_valid;
    logic          o_busy;
    logic          o_done;
`ifdef STRIPES_SEQ_PERF_CNT_EN
    logic [31:0]   o_cyc_cnt, o_stall_cnt, o_bp_cnt;
`endif

    stripes_slice_sequencer #(.TW(TW), .PIPE_LAT(PL), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .i_start(i_start),
        .i_precision(i_precision),
        .i_num_bricks(i_num_bricks),
        .i_num_outputs(i_num_outputs),
        .i_maxpool(i_maxpool),
        .i_window_mask(i_window_mask),
        .i_in_valid(i_in_valid),
        .i_out_ready(i_out_ready),
        .o_in_rd_en(o_in_rd_en),
        .o_first_cycle(o_first_cycle),
        .o_precision(o_precision),
        .o_maxpool(o_maxpool),
        .o_load(o_load),
        .o_out_valid(o_out_valid),
        .o_busy(o_busy),
`ifdef STRIPES_SEQ_PERF_CNT_EN
        .o_cyc_cnt(o_cyc_cnt),
        .o_stall_cnt(o_stall_cnt),
        .o_bp_cnt(o_bp_cnt),
`endif
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       p;
        int       nb;
        int       nout;
        logic [15:0] mask;
        logic     mp;
        bit       stall;
        int       bpg;
        int       bpc;
        int       poke;
    } vec_t;

    typedef struct {
        int       steps;
        int       firsts;
        int       loads;
        int       lval;
        int       ovc;
        int       streak;
        int       prec;
        int       mp;
        int       done_at;
        int       load_at;
        int       stalls;
        int       bps;
    } res_t;

    int   n_chk  = 0;
    int   n_pass = 0;
    res_t sb[$];
    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic res_t expect_of(input vec_t v);
        res_t e;
        int pc, nbc, pnb, run_c;
        bit bp_on;
        pc    = (v.p == 0) ? 1 : ((v.p > 16) ? 16 : v.p);
        nbc   = (v.nb == 0) ? 1 : v.nb;
        pnb   = pc * nbc;
        run_c = v.stall ? 2 * pnb : pnb;
        bp_on = (v.bpc > 0) && (v.bpg < v.nout);
        e.steps   = pnb * v.nout;
        e.firsts  = v.nout;
        e.loads   = v.nout;
        e.lval    = (v.nout > 0) ? int'(v.mask) : 0;
        e.ovc     = v.nout + (bp_on ? v.bpc : 0);
        e.streak  = (v.nout == 0) ? 0 : (bp_on ? v.bpc + 1 : 1);
        e.prec    = pc;
        e.mp      = int'(v.mp);
        e.done_at = v.nout * (run_c + PL + 1) + (bp_on ? v.bpc : 0);
        e.load_at = (v.nout > 0) ? run_c + PL - 1 : -1;
        e.stalls  = v.nout * (run_c - pnb);
        e.bps     = bp_on ? v.bpc : 0;
        return e;
    endfunction

    task automatic run_layer(input int idx, input vec_t v);
        res_t r, e;
        int   g, ov_run;
        bit   seen;
        r = '{default: 0};
        r.done_at = -1;
        r.load_at = -1;
        g = 0;
        ov_run = 0;
        seen = 1'b0;
        sb.push_back(expect_of(v));
        @(negedge clk);
        i_start       = 1'b1;
        i_precision   = 5'(v.p);
        i_num_bricks  = CW'(v.nb);
        i_num_outputs = CW'(v.nout);
        i_maxpool     = v.mp;
        i_window_mask = v.mask;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            i_start     = (c == v.poke);
            i_precision = (c == v.poke) ? 5'd3 : 5'(v.p);
            i_maxpool   = (c == v.poke) ? ~v.mp : v.mp;
            i_in_valid  = v.stall ? (c % 2 == 1) : 1'b1;
            i_out_ready = !(g == v.bpg && ov_run < v.bpc);
            #1;
            if (o_in_rd_en) r.steps++;
            if (o_first_cycle) r.firsts++;
            if (o_load != '0) begin
                r.loads++;
                r.lval = int'(o_load);
                if (r.load_at < 0) r.load_at = c;
            end
            if (o_out_valid) begin
                r.ovc++;
                ov_run++;
                if (i_out_ready) begin
                    if (ov_run > r.streak) r.streak = ov_run;
                    ov_run = 0;
                    g++;
                end
            end
            if (o_done) begin
                r.done_at = c;
                r.prec    = int'(o_precision);
                r.mp      = int'(o_maxpool);
`ifdef STRIPES_SEQ_PERF_CNT_EN
                r.stalls  = int'(o_stall_cnt);
                r.bps     = int'(o_bp_cnt);
`endif
                seen = 1'b1;
                break;
            end
        end
        i_start = 1'b0;
        check($sformatf("v%0d done_seen", idx), int'(seen), 1);
        e = sb.pop_front();
        check($sformatf("v%0d steps", idx), r.steps, e.steps);
        check($sformatf("v%0d first_cycle", idx), r.firsts, e.firsts);
        check($sformatf("v%0d load_count", idx), r.loads, e.loads);
        check($sformatf("v%0d load_val", idx), r.lval, e.lval);
        check($sformatf("v%0d load_at", idx), r.load_at, e.load_at);
        check($sformatf("v%0d out_valid", idx), r.ovc, e.ovc);
        check($sformatf("v%0d ov_streak", idx), r.streak, e.streak);
        check($sformatf("v%0d precision", idx), r.prec, e.prec);
        check($sformatf("v%0d maxpool", idx), r.mp, e.mp);
        check($sformatf("v%0d done_at", idx), r.done_at, e.done_at);
`ifdef STRIPES_SEQ_PERF_CNT_EN
        check($sformatf("v%0d stall_cnt", idx), r.stalls, e.stalls);
        check($sformatf("v%0d bp_cnt", idx), r.bps, e.bps);
`endif
        @(negedge clk);
        #1;
        check($sformatf("v%0d busy_after", idx), int'(o_busy), 0);
        check($sformatf("v%0d done_width", idx), int'(o_done), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " rd_en"}, int'(o_in_rd_en), 0);
        check({tag, " first"}, int'(o_first_cycle), 0);
        check({tag, " prec"}, int'(o_precision), 0);
        check({tag, " maxpool"}, int'(o_maxpool), 0);
        check({tag, " load"}, int'(o_load), 0);
        check({tag, " out_valid"}, int'(o_out_valid), 0);
        check({tag, " busy"}, int'(o_busy), 0);
        check({tag, " done"}, int'(o_done), 0);
    endtask

    initial begin
        int loads, dones;
        // p, nb, nout, mask, mp, stall, bp group, bp cycles, start poke
        vecs[0] = '{4, 2, 1, 16'hFFFF, 1'b0, 1'b0, -1, 0, -1};
        vecs[1] = '{4, 2, 1, 16'hFFFF, 1'b0, 1'b1, -1, 0, -1};
        vecs[2] = '{4, 2, 3, 16'h00F0, 1'b1, 1'b0,  1, 5, -1};
        vecs[3] = '{0, 3, 1, 16'h0001, 1'b0, 1'b0, -1, 0, -1};
        vecs[4] = '{20, 1, 1, 16'hA5A5, 1'b1, 1'b0, -1, 0, -1};
        vecs[5] = '{3, 0, 2, 16'h8001, 1'b0, 1'b0, -1, 0, -1};
        vecs[6] = '{5, 2, 0, 16'h1234, 1'b1, 1'b0, -1, 0, -1};
        vecs[7] = '{8, 1, 1, 16'h0FF0, 1'b0, 1'b0, -1, 0, 2};

        reset = 1'b1;
        i_start = 1'b0;
        i_precision = '0;
        i_num_bricks = '0;
        i_num_outputs = '0;
        i_maxpool = 1'b0;
        i_window_mask = '0;
        i_in_valid = 1'b1;
        i_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_layer(i, vecs[i]);

        // Abort in DRAIN of group 0: p=2, nb=1 -> drain occupies cycles 2..4.
        @(negedge clk);
        i_start       = 1'b1;
        i_precision   = 5'd2;
        i_num_bricks  = CW'(1);
        i_num_outputs = CW'(2);
        i_maxpool     = 1'b1;
        i_window_mask = 16'hFFFF;
        loads = 0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            reset   = (c == 3);
            #1;
            if (c == 3) check("abort in_drain busy", int'(o_busy), 1);
            if (c == 4) check_zero("abort");
            if (o_load != '0) loads++;
            if (o_done) dones++;
        end
        reset = 1'b0;
        check("abort loads", loads, 0);
        check("abort dones", dones, 0);

        run_layer(8, vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stripes_slice_sequencer.md
# stripes_slice_sequencer

Control sequencer for one Stripes SIP-array slice (Tn=1 filter, Tw windows). Takes a layer configuration (activation precision, synapse bricks per output, output groups), steps the slice's bit-serial pipeline one bit-slice per cycle, and drives the slice's first-cycle, precision, maxpool and load controls. It also handles the valid/ready handshake with the eDRAM/NBin input stream and the output bus.

## Interface
Parameters:
- TW, 16, windows per slice; width of `o_load` and `i_window_mask`.
- PIPE_LAT, 3, cycles from the last bit-slice step to slice results being stable (DRAIN length, ≥1).
- CNT_W, 16, width of brick and output-group counters.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `i_start`  in  1  start a layer; sampled only in IDLE
- `i_precision`  in  5  activation bits per value, legal 1..16; 0 is treated as 1, values >16 are treated as 16
- `i_num_bricks`  in  CNT_W  Ti-input bricks per output; 0 is treated as 1
- `i_num_outputs`  in  CNT_W  output groups in the layer; 0 means finish immediately
- `i_maxpool`  in  1  layer is max-pool
- `i_window_mask`  in  TW  active windows
- `i_in_valid`  in  1  a bit-slice of inputs/synapses is available
- `i_out_ready`  in  1  bus accepts the result
- `o_in_rd_en`  out  1  consume the current bit-slice (step)
- `o_first_cycle`  out  1  first step of an output accumulation
- `o_precision`  out  5  latched, clamped precision
- `o_maxpool`  out  1  latched maxpool flag
- `o_load`  out  TW  slice output-register load strobe
- `o_out_valid`  out  1  slice result valid on bus
- `o_busy`  out  1  not in IDLE
- `o_done`  out  1  one-cycle layer-complete pulse

## Operation
- States: IDLE, RUN, DRAIN, OUT, DONE.
- IDLE: when `i_start`=1, latch the config with clamping applied.
  - If `i_num_outputs`=0, go to DONE.
  - Otherwise clear the bit, brick and group counters and go to RUN.
- RUN: `o_in_rd_en` = `i_in_valid` (combinational). Each step advances the counters:
  - bit counter runs 0..p-1;
  - on bit wrap, the brick counter runs 0..nb-1.
- `o_first_cycle` = `o_in_rd_en` AND bit==0 AND brick==0.
- On the step with bit==p-1 AND brick==nb-1, go to DRAIN. Both counters return to 0.
- While `i_in_valid`=0 in RUN: no step, counters hold, `o_first_cycle`=0 (stall).
- DRAIN: counts PIPE_LAT cycles. On the last DRAIN cycle, `o_load` = latched window mask for one cycle (zero at all other times). Then go to OUT.
- OUT: `o_out_valid`=1, held until `i_out_ready`=1. On handshake:
  - if group==num_outputs-1, go to DONE;
  - otherwise group++ and return to RUN.
- DONE: `o_done`=1 for exactly one cycle, then go to IDLE.
- `i_start` while not in IDLE is ignored. Config inputs are not re-sampled mid-layer.
- `o_precision` and `o_maxpool` update only on accepted start; they hold their values through IDLE.
- `o_busy`=1 in every state except IDLE.

## Timing
- Reset: state=IDLE, all counters 0, and every output is 0: `o_in_rd_en`, `o_first_cycle`, `o_load`, `o_out_valid`, `o_busy`, `o_done`, `o_precision`, `o_maxpool`.
- Reset asserted mid-layer aborts within the same edge: outputs are 0 on the next cycle and no `o_done` pulse is produced.
- Start latency: `i_start` sampled at edge N gives RUN from cycle N+1. The first possible step is at cycle N+1.
- With no stalls and no backpressure, one output group takes p·nb steps, then PIPE_LAT DRAIN cycles, then ≥1 OUT cycle.
- `i_out_ready` already high on the first OUT cycle completes the handshake in that cycle.
- Simultaneous `i_in_valid` and the final step: the step is taken, then DRAIN follows.
- Counters never wrap past their limits. With p=16 and nb=2^CNT_W−1, no overflow occurs.

## Configuration
- `STRIPES_SEQ_PERF_CNT_EN` defined adds three extra outputs, each 32 bits and saturating:
  - `o_cyc_cnt`: busy cycles;
  - `o_stall_cnt`: RUN cycles with `i_in_valid`=0;
  - `o_bp_cnt`: OUT cycles with `i_out_ready`=0.
- These counters clear on reset and on accepted start.
- Macro undefined: these ports and the counter logic do not exist. Behaviour is otherwise identical.

## Test plan
- p=4, nb=2, outputs=1, PIPE_LAT=3, valid/ready tied high, mask=16'hFFFF:
  - 8 steps;
  - `o_first_cycle` only on step 0;
  - `o_load`=FFFF one cycle after 3 DRAIN cycles;
  - `o_out_valid` for 1 cycle;
  - `o_done` 1 cycle later; `o_busy` low after that.
- Same config with `i_in_valid` low on every other cycle: still exactly 8 steps, spanning 16 cycles. With the macro enabled, `o_stall_cnt`=8.
- outputs=3 with `i_out_ready` held low for 5 OUT cycles on group 1: `o_out_valid` stays high for 6 cycles, then RUN resumes. `o_first_cycle` fires exactly 3 times in total.
- Clamping and zero counts:
  - `i_precision`=0 → `o_precision`=1;
  - `i_precision`=20 → `o_precision`=16;
  - nb=0 → behaves as 1;
  - outputs=0 → DONE the cycle after start, with no steps.
- Reset asserted during DRAIN of group 0: all outputs 0 the next cycle, and no `o_load` or `o_done` is produced. A new start then behaves nominally.
- `i_start` pulsed during RUN with a different precision: ignored, and `o_precision` is unchanged.
